updown_counter: RTL and testbench

- Loadable, wrapping binary up/down counter with a terminal-count flag, a sticky wrap interrupt and a saturating wrap-event counter.
- It is the design-side stage feeding the counter property checker: `count`, `tc`, `en`, `up_down`, `load` and `load_value` connect one-to-one to the checker's ports.
- The optional Gray output feeds the Gray-counter checker.

---
 rtl/updown_counter.sv | 84 ++++++++
 tb/tb_updown_counter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// Loadable wrapping up/down counter with terminal-count flag, sticky wrap irq
// and saturating wrap counter. Define UPDOWN_COUNTER_GRAY_EN to add gray_count.
module updown_counter #(
  parameter int WIDTH   = 8,
  parameter int WRAPS_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               up_down,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_value,
  input  logic               irq_clr,
  output logic [WIDTH-1:0]   count,
  output logic               tc,
  output logic               irq,
  output logic [WRAPS_W-1:0] wraps
`ifdef UPDOWN_COUNTER_GRAY_EN
  ,
  output logic [WIDTH-1:0]   gray_count
`endif
);

  localparam logic [WIDTH-1:0]   CountMax = {WIDTH{1'b1}};
  localparam logic [WRAPS_W-1:0] WrapsMax = {WRAPS_W{1'b1}};

  logic [WIDTH-1:0]   count_q, count_d;
  logic               irq_q, irq_d;
  logic [WRAPS_W-1:0] wraps_q, wraps_d;
  logic               wrap_evt;

  assign tc       = up_down ? (count_q == CountMax) : (count_q == '0);
  assign wrap_evt = !load && en && tc;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    count_d = count_q;
    if (load)         count_d = load_value;
    else if (en)      count_d = up_down ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
  end

  // A wrap event in the same cycle as irq_clr wins, leaving irq set and wraps at 1.
  always_comb begin
    irq_d   = irq_q;
    wraps_d = wraps_q;
    if (irq_clr) begin
      irq_d   = 1'b0;
      wraps_d = '0;
    end
    if (wrap_evt) begin
      irq_d = 1'b1;
      if (irq_clr)                 wraps_d = WRAPS_W'(1);
      else if (wraps_q != WrapsMax) wraps_d = wraps_q + WRAPS_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      irq_q   <= 1'b0;
      wraps_q <= '0;
    end else begin
      count_q <= count_d;
      irq_q   <= irq_d;
      wraps_q <= wraps_d;
    end
  end

  assign count = count_q;
  assign irq   = irq_q;
  assign wraps = wraps_q;

`ifdef UPDOWN_COUNTER_GRAY_EN
  // Encoded from the next count so gray_count lines up with count in the same cycle.
  logic [WIDTH-1:0] gray_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gray_q <= '0;
    else        gray_q <= count_d ^ (count_d >> 1);
  end
  assign gray_count = gray_q;
`endif

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter: table vectors, corner sequences and
// random stimulus against an arithmetic model; two instances (WRAPS_W 4 and 2).
module tb_updown_counter;

  localparam int WIDTH = 8;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic rst_n, en, up_down, load, irq_clr;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count, count2;
  logic tc, tc2, irq, irq2;
  logic [3:0] wraps;
  logic [1:0] wraps2;
`ifdef UPDOWN_COUNTER_GRAY_EN
  logic [WIDTH-1:0] gray, gray2;
`endif

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(WIDTH), .WRAPS_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_down(up_down), .load(load),
    .load_value(load_value), .irq_clr(irq_clr), .count(count), .tc(tc),
    .irq(irq), .wraps(wraps)
`ifdef UPDOWN_COUNTER_GRAY_EN
    , .gray_count(gray)
`endif
  );

  updown_counter #(.WIDTH(WIDTH), .WRAPS_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .up_down(up_down), .load(load),
    .load_value(load_value), .irq_clr(irq_clr), .count(count2), .tc(tc2),
    .irq(irq2), .wraps(wraps2)
`ifdef UPDOWN_COUNTER_GRAY_EN
    , .gray_count(gray2)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: plain integers.
  int m_count = 0, m_w4 = 0, m_w2 = 0;
  bit m_irq = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v, input int lim);
    return (v < lim) ? v + 1 : lim;
  endfunction

  // Advance the model using the inputs presented to the coming edge, then clock.
  task automatic tick();
    bit term, wrap;
    int nc;
    term = up_down ? (m_count == MAXV) : (m_count == 0);
    wrap = !load && en && term;
    if (load)    nc = int'(load_value);
    else if (en) nc = up_down ? (m_count + 1) % (MAXV + 1) : (m_count + MAXV) % (MAXV + 1);
    else         nc = m_count;
    if (irq_clr) begin
      m_w4 = wrap ? 1 : 0;
      m_w2 = wrap ? 1 : 0;
    end else if (wrap) begin
      m_w4 = sat_inc(m_w4, 15);
      m_w2 = sat_inc(m_w2, 3);
    end
    if (wrap)         m_irq = 1'b1;
    else if (irq_clr) m_irq = 1'b0;
    @(posedge clk);
    #1;
    m_count = nc;
  endtask

  task automatic check_model(input string tag);
    bit m_tc;
    m_tc = up_down ? (m_count == MAXV) : (m_count == 0);
    check({tag, ".count"},  32'(count),  32'(m_count));
    check({tag, ".tc"},     32'(tc),     32'(m_tc));
    check({tag, ".irq"},    32'(irq),    32'(m_irq));
    check({tag, ".wraps"},  32'(wraps),  32'(m_w4));
    check({tag, ".count2"}, 32'(count2), 32'(m_count));
    check({tag, ".tc2"},    32'(tc2),    32'(m_tc));
    check({tag, ".irq2"},   32'(irq2),   32'(m_irq));
    check({tag, ".wraps2"}, 32'(wraps2), 32'(m_w2));
`ifdef UPDOWN_COUNTER_GRAY_EN
    check({tag, ".gray"},   32'(gray),   32'(m_count ^ (m_count >> 1)));
    check({tag, ".gray2"},  32'(gray2),  32'(m_count ^ (m_count >> 1)));
`endif
  endtask

  task automatic set_in(input bit e, input bit ud, input bit ld, input int lv, input bit clr);
    en = e; up_down = ud; load = ld; load_value = WIDTH'(lv); irq_clr = clr;
  endtask

  typedef struct {
    bit        en, up_down, load, irq_clr;
    logic [7:0] lv;
    logic [7:0] exp_count;
    bit        exp_tc, exp_irq;
    logic [3:0] exp_wraps;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // en, up_down, load, irq_clr, lv, count, tc, irq, wraps
    vecs[0]  = '{0, 1, 1, 0, 8'hFD, 8'hFD, 0, 0, 0};  // up wrap setup
    vecs[1]  = '{1, 1, 0, 0, 8'h00, 8'hFE, 0, 0, 0};
    vecs[2]  = '{1, 1, 0, 0, 8'h00, 8'hFF, 1, 0, 0};
    vecs[3]  = '{1, 1, 0, 0, 8'h00, 8'h00, 0, 1, 1};
    vecs[4]  = '{1, 1, 0, 0, 8'h00, 8'h01, 0, 1, 1};
    vecs[5]  = '{0, 0, 1, 1, 8'h01, 8'h01, 0, 0, 0};  // down wrap setup, clear history
    vecs[6]  = '{1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0};
    vecs[7]  = '{1, 0, 0, 0, 8'h00, 8'hFF, 0, 1, 1};
    vecs[8]  = '{1, 1, 0, 0, 8'h00, 8'h00, 0, 1, 2};
    vecs[9]  = '{1, 0, 0, 0, 8'h00, 8'hFF, 0, 1, 3};
    vecs[10] = '{1, 1, 1, 0, 8'h42, 8'h42, 0, 1, 3};  // load beats increment at MAX
    vecs[11] = '{0, 1, 0, 1, 8'h00, 8'h42, 0, 0, 0};  // clear alone

    set_in(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #12;
    check("reset.count", 32'(count), 0);
    check("reset.tc_down", 32'(tc), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-count at 0x37.
    set_in(0, 1, 1, 8'h36, 0); tick();
    set_in(1, 1, 0, 0, 0);     tick();
    check("pre_rst.count", 32'(count), 32'h37);
    #2;
    rst_n = 1'b0;
    m_count = 0; m_irq = 0; m_w4 = 0; m_w2 = 0;
    #1;
    check("async_rst.count", 32'(count), 0);
    up_down = 1'b0; #1;
    check("rst.tc_down", 32'(tc), 1);
    up_down = 1'b1; #1;
    check("rst.tc_up", 32'(tc), 0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold.count", 32'(count), 0);
      check_model("hold");
    end

    // Table vectors.
    foreach (vecs[i]) begin
      set_in(vecs[i].en, vecs[i].up_down, vecs[i].load, int'(vecs[i].lv), vecs[i].irq_clr);
      tick();
      check($sformatf("vec%0d.count", i),  32'(count),  32'(vecs[i].exp_count));
      check($sformatf("vec%0d.tc", i),     32'(tc),     32'(vecs[i].exp_tc));
      check($sformatf("vec%0d.irq", i),    32'(irq),    32'(vecs[i].exp_irq));
      check($sformatf("vec%0d.wraps", i),  32'(wraps),  32'(vecs[i].exp_wraps));
      check($sformatf("vec%0d.wraps2", i), 32'(wraps2), 32'(vecs[i].exp_wraps));
    end

    // Saturation: alternate direction at the boundary so every step wraps.
    set_in(0, 1, 1, 8'hFF, 0); tick();
    for (int i = 1; i <= 5; i++) begin
      set_in(1, (i % 2 == 1), 0, 0, 0);
      tick();
      check($sformatf("sat%0d.wraps2", i), 32'(wraps2), (i < 3) ? i : 3);
      check($sformatf("sat%0d.wraps", i),  32'(wraps),  i);
      check($sformatf("sat%0d.irq", i),    32'(irq),    1);
    end
    // count is now 0x00 (after up step 5); decrement wraps while clearing.
    set_in(1, 0, 0, 0, 1); tick();
    check("race.irq", 32'(irq), 1);
    check("race.wraps", 32'(wraps), 1);
    check("race.wraps2", 32'(wraps2), 1);
    set_in(0, 0, 0, 0, 1); tick();
    check("clr.irq", 32'(irq), 0);
    check("clr.wraps", 32'(wraps), 0);
    check("clr.wraps2", 32'(wraps2), 0);
    check_model("clr");

`ifdef UPDOWN_COUNTER_GRAY_EN
    begin
      logic [WIDTH-1:0] prev;
      set_in(0, 1, 1, 0, 0); tick();
      check_model("gray_start");
      prev = gray;
      for (int i = 0; i <= MAXV; i++) begin
        set_in(1, 1, 0, 0, 0);
        tick();
        check_model("gray_walk");
        check("gray.onebit", 32'($countones(prev ^ gray)), 1);
        prev = gray;
      end
      check("gray.wrap_end", 32'(gray), 0);
    end
`endif

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      int pick;
      int lv;
      pick = $urandom_range(0, 2);
      lv = (pick == 0) ? 0 : (pick == 1) ? MAXV : $urandom_range(0, MAXV);
      set_in(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
             ($urandom_range(0, 15) == 0), lv, ($urandom_range(0, 31) == 0));
      tick();
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
